lbp_hist: RTL and testbench

LBP code histogram accumulator on the LBP output interface. Snoops the `lbp_valid`/`lbp_addr`/`lbp_data` write stream the LBP engine drives toward result memory and counts occurrences of each of the 256 codes. After the engine asserts `finish`, it drains the 256 bins over a valid/ready stream to the downstream feature/classifier stage.

---
 rtl/lbp_hist.sv | 115 +++++++++++
 tb/tb_lbp_hist.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lbp_hist.sv
//------------------------------------------------------------------------------
// lbp_hist : LBP code histogram, snoops the LBP result write stream and drains
//            256 saturating 15-bit bins over a valid/ready stream after finish.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lbp_hist #(
    parameter int IMG_W       = 128,
    parameter int IMG_H       = 128,
    parameter int EXCL_BORDER = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lbp_valid,
    input  logic [13:0] lbp_addr,
    input  logic [7:0]  lbp_data,
    input  logic        finish,
    output logic        hist_valid,
    input  logic        hist_ready,
    output logic [7:0]  hist_bin,
    output logic [14:0] hist_count,
    output logic [14:0] pix_count,
    output logic        hist_done
);

    localparam int          c_col_bits = $clog2(IMG_W);
    localparam logic [14:0] c_sat      = 15'h7fff;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    logic [14:0] r_bins [256];
    logic [14:0] r_pix;
    logic [7:0]  r_idx;
    logic        r_valid;
    logic        r_done;

    logic [13:0] w_row;
    logic [13:0] w_col;
    logic        w_border;
    logic        w_accept;
    logic [14:0] w_bin_cur;

    // IMG_W is a power of two, so row/col are a plain shift and mask of the address.
    assign w_row     = lbp_addr >> c_col_bits;
    assign w_col     = lbp_addr & 14'(IMG_W - 1);
    assign w_border  = (w_row == 14'd0) || (w_row == 14'(IMG_H - 1)) ||
                       (w_col == 14'd0) || (w_col == 14'(IMG_W - 1));
    assign w_accept  = lbp_valid && (r_state == ST_ACC) &&
                       ((EXCL_BORDER == 0) || !w_border);
    assign w_bin_cur = r_bins[lbp_data];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_ACC;
            r_idx   <= 8'd0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_pix   <= 15'd0;
            for (int k = 0; k < 256; k++) begin
                r_bins[k] <= 15'd0;
            end
        end else begin
            // A write in the same cycle that finish is sampled still counts.
            if (w_accept) begin
                if (w_bin_cur != c_sat) begin
                    r_bins[lbp_data] <= w_bin_cur + 15'd1;
                end
                if (r_pix != c_sat) begin
                    r_pix <= r_pix + 15'd1;
                end
            end
            case (r_state)
                ST_ACC: begin
                    if (finish) begin
                        r_state <= ST_DRAIN;
                        r_valid <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (hist_ready) begin
                        if (r_idx == 8'hff) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 8'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_ACC;
                end
            endcase
        end
    end

    // Bins are frozen during the drain, so a read mux keeps the count stable under stalls.
    assign hist_valid = r_valid;
    assign hist_bin   = r_idx;
    assign hist_count = r_valid ? r_bins[r_idx] : 15'd0;
    assign pix_count  = r_pix;
    assign hist_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_lbp_hist.sv
//------------------------------------------------------------------------------
// tb_lbp_hist : directed self-checking bench for lbp_hist (plus a border-excluding
//               instance driven alongside the full-frame sweep).
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_lbp_hist;

    logic        clk = 1'b0;
    logic        reset;
    logic        lbp_valid, finish, hist_ready;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        hist_valid, hist_done;
    logic [7:0]  hist_bin;
    logic [14:0] hist_count, pix_count;

    logic        b_valid, b_finish, b_ready;
    logic [13:0] b_addr;
    logic [7:0]  b_data;
    logic        b_hist_valid, b_hist_done;
    logic [7:0]  b_hist_bin;
    logic [14:0] b_hist_count, b_pix_count;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_bins [256];

    always #5 clk = ~clk;

    lbp_hist #(.IMG_W(128), .IMG_H(128), .EXCL_BORDER(0)) dut (
        .clk(clk), .reset(reset), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
        .lbp_data(lbp_data), .finish(finish), .hist_valid(hist_valid),
        .hist_ready(hist_ready), .hist_bin(hist_bin), .hist_count(hist_count),
        .pix_count(pix_count), .hist_done(hist_done)
    );

    lbp_hist #(.IMG_W(128), .IMG_H(128), .EXCL_BORDER(1)) dut_b (
        .clk(clk), .reset(reset), .lbp_valid(b_valid), .lbp_addr(b_addr),
        .lbp_data(b_data), .finish(b_finish), .hist_valid(b_hist_valid),
        .hist_ready(b_ready), .hist_bin(b_hist_bin), .hist_count(b_hist_count),
        .pix_count(b_pix_count), .hist_done(b_hist_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are then settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        for (int k = 0; k < 256; k++) exp_bins[k] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; lbp_valid = 1'b0; finish = 1'b0; hist_ready = 1'b1;
        b_valid = 1'b0; b_finish = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        clear_exp();
    endtask

    task automatic wr(input logic [13:0] a, input logic [7:0] d);
        lbp_valid = 1'b1; lbp_addr = a; lbp_data = d;
        tick();
        lbp_valid = 1'b0;
    endtask

    // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating.
    // Stops after stop_at bins are accepted; a full drain also checks done and latency.
    task automatic drain(input int mode, input int stop_at, input string tag);
        int i = 0;
        int cyc = 0;
        int stalls = 0;
        while (i < stop_at && cyc < 3000) begin
            hist_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            chk({tag, "_valid"}, 32'(hist_valid), 32'd1);
            chk({tag, "_bin"}, 32'(hist_bin), 32'(i));
            chk({tag, "_count"}, 32'(hist_count), 32'(exp_bins[i]));
            if (!hist_ready) stalls++;
            tick();
            if (hist_ready) i++;
            cyc++;
        end
        chk({tag, "_bound"}, 32'(i), 32'(stop_at));
        if (stop_at == 256) begin
            chk({tag, "_latency"}, 32'(cyc), 32'(256 + stalls));
            chk({tag, "_done"}, 32'(hist_done), 32'd1);
            chk({tag, "_valid_off"}, 32'(hist_valid), 32'd0);
        end
        hist_ready = 1'b1;
    endtask

    initial begin
        b_ready  = 1'b1;
        lbp_addr = '0; lbp_data = '0; b_addr = '0; b_data = '0;
        do_reset();

        chk("rst_valid", 32'(hist_valid), 32'd0);
        chk("rst_bin", 32'(hist_bin), 32'd0);
        chk("rst_count", 32'(hist_count), 32'd0);
        chk("rst_pix", 32'(pix_count), 32'd0);
        chk("rst_done", 32'(hist_done), 32'd0);

        // Full 128x128 sweep: code = addr[7:0] on dut, code 0 on the border-excluding dut_b.
        for (int a = 0; a < 16384; a++) begin
            lbp_valid = 1'b1; lbp_addr = 14'(a); lbp_data = 8'(a);
            b_valid = 1'b1; b_addr = 14'(a); b_data = 8'd0;
            tick();
        end
        lbp_valid = 1'b0; b_valid = 1'b0;
        for (int k = 0; k < 256; k++) exp_bins[k] = 64;
        finish = 1'b1; b_finish = 1'b1;
        chk("sweep_valid_pre", 32'(hist_valid), 32'd0);
        tick();
        chk("sweep_pix", 32'(pix_count), 32'd16384);
        chk("border_bin0", 32'(b_hist_count), 32'd15876);
        chk("border_pix", 32'(b_pix_count), 32'd15876);
        drain(0, 256, "sweep");
        chk("border_done", 32'(b_hist_done), 32'd1);

        // DONE ignores further writes and finish.
        wr(14'd5, 8'd7);
        tick();
        chk("done_pix_hold", 32'(pix_count), 32'd16384);
        chk("done_hold", 32'(hist_done), 32'd1);

        // Five writes of 0xA5, then finish on its own cycle.
        do_reset();
        for (int j = 0; j < 5; j++) begin
            wr(14'(10 + j), 8'hA5);
            if (j == 0) chk("first_pix", 32'(pix_count), 32'd1);
        end
        exp_bins[8'hA5] = 5;
        finish = 1'b1;
        tick();
        chk("a5_pix", 32'(pix_count), 32'd5);
        drain(0, 256, "a5");

        // Same, with the 5th write sampled with finish; a following write is ignored.
        do_reset();
        for (int j = 0; j < 4; j++) wr(14'(10 + j), 8'hA5);
        lbp_valid = 1'b1; lbp_addr = 14'd14; lbp_data = 8'hA5; finish = 1'b1;
        tick();
        hist_ready = 1'b0;
        tick();
        lbp_valid = 1'b0;
        exp_bins[8'hA5] = 5;
        chk("a5fin_pix", 32'(pix_count), 32'd5);
        drain(0, 256, "a5fin");

        // Saturation with repeated addresses, then a stalled drain.
        do_reset();
        for (int j = 0; j < 40000; j++) begin
            lbp_valid = 1'b1; lbp_addr = 14'(j % 100); lbp_data = 8'h03;
            tick();
        end
        lbp_valid = 1'b0;
        exp_bins[3] = 32767;
        chk("sat_pix", 32'(pix_count), 32'd32767);
        finish = 1'b1;
        tick();
        drain(1, 256, "stall");

        // Reset mid-drain after bin 100 is accepted, then a short fresh run.
        do_reset();
        wr(14'd1, 8'd9);
        wr(14'd2, 8'd200);
        wr(14'd3, 8'd9);
        exp_bins[9] = 2; exp_bins[200] = 1;
        finish = 1'b1;
        tick();
        drain(0, 101, "pre_rst");
        reset = 1'b1; finish = 1'b0;
        tick();
        reset = 1'b0;
        chk("midrst_valid", 32'(hist_valid), 32'd0);
        chk("midrst_pix", 32'(pix_count), 32'd0);
        chk("midrst_bin", 32'(hist_bin), 32'd0);
        clear_exp();
        wr(14'd40, 8'd17);
        wr(14'd41, 8'd17);
        wr(14'd42, 8'd250);
        exp_bins[17] = 2; exp_bins[250] = 1;
        finish = 1'b1;
        tick();
        chk("rerun_pix", 32'(pix_count), 32'd3);
        drain(0, 256, "rerun");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
